// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Memory-side responder for the M-stage data port of the pipeline. It takes
//   one load or store at a time and adds WAIT_CYCLES of access latency. While
//   the access is outstanding it holds the pipeline through stall_req. Stores
//   can be byte, half or word wide and are placed into the matching byte lanes.
//   A misaligned request completes without writing memory and flags addr_err.
//
// Parameters
//   AW           word-address width; the RAM holds 2**AW 32-bit words
//   WAIT_CYCLES  extra access-latency cycles (0..15)
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous reset, active high
//   req        access valid; held stable with we/size/addr/wdata until stall_req=0
//   we         1 = store, 0 = load
//   size       0 = byte, 1 = half, 2 = word, 3 = illegal (treated as misaligned)
//   addr       byte address; only addr[AW+1:0] is used
//   wdata      right-justified store data
//   rdata      raw aligned word at addr[AW+1:2]; valid in RESP, held afterwards
//   stall_req  freeze request to the hazard unit
//   addr_err   one-cycle pulse in RESP when the completed request was misaligned
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall_req,
    output logic        addr_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          addr_err_q, addr_err_d;
    logic [31:0]   rdata_q;

    // Request captured in IDLE; the access always uses these copies.
    logic          we_q;
    logic [1:0]    size_q;
    logic [AW-1:0] idx_q;
    logic [1:0]    off_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [2**AW];

    logic          do_access;
    logic          misalign;
    logic [3:0]    lane_sel;
    logic [3:0]    wr_en;
    logic [31:0]   wr_data;

    // Address bits above the RAM index are deliberately ignored (addresses wrap).
    logic          unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    // The access fires on the last BUSY cycle, i.e. when the latency counter is spent.
    assign do_access = (state_q == S_BUSY) && (cnt_q == 4'd0);

    assign misalign = ((size_q == 2'd1) && off_q[0])
                   || ((size_q == 2'd2) && (off_q != 2'd0))
                   ||  (size_q == 2'd3);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_sel[gi] = (size_q == 2'd0) ? (off_q == LANE)
                                : (size_q == 2'd1) ? (off_q[1] == LANE[1])
                                :                    1'b1;
            // A reset on the access edge aborts the write.
            assign wr_en[gi] = do_access && we_q && !misalign && !rst && lane_sel[gi];
            // Narrow stores are replicated across the word so every lane sees its data.
            assign wr_data[gi*8 +: 8] = (size_q == 2'd0) ? wdata_q[7:0]
                                      : (size_q == 2'd1) ? wdata_q[(gi % 2)*8 +: 8]
                                      :                    wdata_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_err_d = 1'b0;
        stall_req  = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_req = req;
                if (req) begin
                    state_d = S_BUSY;
                    cnt_d   = WAIT_INIT;
                end
            end
            S_BUSY: begin
                stall_req = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d    = S_RESP;
                    addr_err_d = misalign;
                end
            end
            S_RESP: begin
                // req seen here is the request just served, so it is not restarted.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_err_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_err_q <= addr_err_d;
            // Read-before-write: a store returns the word as it was before the write.
            if (do_access) begin
                rdata_q <= mem[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == S_IDLE) && req) begin
            we_q    <= we;
            size_q  <= size;
            idx_q   <= addr[AW+1:2];
            off_q   <= addr[1:0];
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) begin
                mem[idx_q][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    assign rdata    = rdata_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. Four instances share the stimulus bus;
//   sel picks which one sees req and whose outputs are observed:
//     0: AW=10, WAIT_CYCLES=1   1: AW=10, WAIT_CYCLES=0
//     2: AW=10, WAIT_CYCLES=3   3: AW=4,  WAIT_CYCLES=1
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          sel;

    logic [3:0]  req_v;
    logic [31:0] rd   [4];
    logic [3:0]  st;
    logic [3:0]  er;

    logic [31:0] rd_m;
    logic        st_m;
    logic        er_m;

    int n_checks = 0;
    int n_pass   = 0;
    int resp_cnt = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_req
            assign req_v[gi] = req && (sel == gi);
        end
    endgenerate

    always_comb begin
        rd_m = rd[sel];
        st_m = st[sel];
        er_m = er[sel];
    end

    dmem_responder #(.AW(10), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rd[0]), .stall_req(st[0]), .addr_err(er[0]));
    dmem_responder #(.AW(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rd[1]), .stall_req(st[1]), .addr_err(er[1]));
    dmem_responder #(.AW(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .req(req_v[2]), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rd[2]), .stall_req(st[2]), .addr_err(er[2]));
    dmem_responder #(.AW(4), .WAIT_CYCLES(1)) u_aw4 (
        .clk(clk), .rst(rst), .req(req_v[3]), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rd[3]), .stall_req(st[3]), .addr_err(er[3]));

    // Every RESP cycle of the selected instance: request still up, stall released.
    always @(negedge clk) begin
        if (req && !st_m) resp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One complete access: drive after a rising edge, count stall cycles at
    // falling edges until stall drops (RESP), then check the response.
    task automatic xfer(input int k, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic chk_rd, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_stall, input string tag);
        int  n;
        bit  done;
        @(posedge clk);
        #1;
        sel = k; req = 1'b1; we = w; size = sz; addr = a; wdata = d;
        n = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (st_m) n++;
            else done = 1;
        end
        check({tag, "_resp"}, 32'(st_m), 32'd0);
        check({tag, "_stall"}, 32'(n), 32'(exp_stall));
        check({tag, "_err"}, 32'(er_m), 32'(exp_err));
        if (chk_rd) check({tag, "_rdata"}, rd_m, exp_rd);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; addr = '0; wdata = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", 32'(st_m), 32'(req));
        check("rst_rdata", rd_m, 32'd0);
        check("rst_err", 32'(er_m), 32'd0);

        // WAIT_CYCLES=1: basic word store/load
        xfer(0, 1, 2'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 3, "st_w_10");
        xfer(0, 0, 2'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, 3, "ld_w_10");
        // Lane placement: byte then half over a known word
        xfer(0, 1, 2'd2, 32'h10, 32'h11223344, 1, 32'hDEADBEEF, 0, 3, "st_w_pre");
        xfer(0, 1, 2'd0, 32'h13, 32'h000000AA, 1, 32'h11223344, 0, 3, "st_b_13");
        xfer(0, 0, 2'd2, 32'h10, 32'h0, 1, 32'hAA223344, 0, 3, "ld_after_b");
        xfer(0, 1, 2'd1, 32'h10, 32'h00005566, 1, 32'hAA223344, 0, 3, "st_h_10");
        xfer(0, 0, 2'd2, 32'h10, 32'h0, 1, 32'hAA225566, 0, 3, "ld_after_h");
        // Misaligned word store: no write, pre-write word returned, one-cycle pulse
        xfer(0, 1, 2'd2, 32'h12, 32'h99999999, 1, 32'hAA225566, 1, 3, "st_w_12_mis");
        idle();
        @(negedge clk);
        check("err_pulse_end", 32'(er_m), 32'd0);
        check("rdata_hold", rd_m, 32'hAA225566);
        xfer(0, 0, 2'd2, 32'h10, 32'h0, 1, 32'hAA225566, 0, 3, "ld_unchanged");
        xfer(0, 0, 2'd1, 32'h11, 32'h0, 1, 32'hAA225566, 1, 3, "ld_h_11_mis");
        xfer(0, 0, 2'd3, 32'h10, 32'h0, 1, 32'hAA225566, 1, 3, "ld_size3");
        // Upper byte-of-half and upper half
        xfer(0, 1, 2'd0, 32'h11, 32'h00000077, 1, 32'hAA225566, 0, 3, "st_b_11");
        xfer(0, 1, 2'd1, 32'h12, 32'h0000BEEF, 1, 32'hAA227766, 0, 3, "st_h_12");
        xfer(0, 0, 2'd2, 32'h10, 32'h0, 1, 32'hBEEF7766, 0, 3, "ld_final_10");
        idle();

        // Latency for WAIT_CYCLES=0 and 3
        xfer(1, 1, 2'd2, 32'h0, 32'h01020304, 0, 32'h0, 0, 2, "w0_st");
        xfer(1, 0, 2'd2, 32'h0, 32'h0, 1, 32'h01020304, 0, 2, "w0_ld");
        idle();
        xfer(2, 1, 2'd2, 32'h4, 32'h0A0B0C0D, 0, 32'h0, 0, 5, "w3_st");
        xfer(2, 0, 2'd2, 32'h4, 32'h0, 1, 32'h0A0B0C0D, 0, 5, "w3_ld");
        idle();

        // Back-to-back loads: one RESP per request
        repeat (2) @(posedge clk);
        resp_cnt = 0;
        xfer(1, 0, 2'd2, 32'h0, 32'h0, 1, 32'h01020304, 0, 2, "b2b_1");
        xfer(1, 0, 2'd2, 32'h0, 32'h0, 1, 32'h01020304, 0, 2, "b2b_2");
        idle();
        repeat (3) @(posedge clk);
        check("b2b_resp_cnt", 32'(resp_cnt), 32'd2);

        // Reset during the 2nd BUSY cycle of a store aborts the write
        xfer(0, 1, 2'd2, 32'h20, 32'h12345678, 0, 32'h0, 0, 3, "st_w_20");
        @(posedge clk);
        #1;
        sel = 0; req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'hCAFEF00D;
        @(posedge clk);            // IDLE -> BUSY
        @(posedge clk);            // first BUSY cycle ends
        #1 rst = 1'b1; req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_stall", 32'(st_m), 32'(req));
        check("abort_rdata", rd_m, 32'd0);
        xfer(0, 0, 2'd2, 32'h20, 32'h0, 1, 32'h12345678, 0, 3, "abort_ld_20");
        idle();

        // AW=4: 0x40 wraps onto word 0
        xfer(3, 1, 2'd2, 32'h40, 32'h5A5AA5A5, 0, 32'h0, 0, 3, "aw4_st_40");
        xfer(3, 0, 2'd2, 32'h00, 32'h0, 1, 32'h5A5AA5A5, 0, 3, "aw4_ld_00");
        idle();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
